// File: rtl/ifmap_pkg.sv
// Shared defaults and the fetch-state encoding for the ifmap read streamer.
package ifmap_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int DIM_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifmap_fetch_if.sv
// Output word stream (valid/ready with end-of-tile marker) between the fetcher and its consumer.
interface ifmap_fetch_if
  import ifmap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/ifmap_fetch_fifo.sv
// Show-ahead FIFO: the head entry is visible on rdata_o whenever the FIFO is non-empty.
module ifmap_fetch_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the empty flag gates what the consumer sees.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifmap_fetch.sv
// Sweeps a 2-D tile of ifmap_rom addresses in raster order and streams the returned
// words through a small FIFO, issuing only while the FIFO can absorb every in-flight word.
module ifmap_fetch
  import ifmap_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  ifmap_fetch_if.master     out_if,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, stride_q, stride_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              issue_q, issue_d, last_q, last_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_empty, pop, credit, col_end, row_end;

  // A word still travelling through the ROM already owns a FIFO slot.
  assign inflight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, issue_q};
  assign credit   = inflight < (CNT_W+1)'(FIFO_DEPTH);
  assign col_end  = (col_q == width_q - DIM_W'(1));
  assign row_end  = (row_q == height_q - DIM_W'(1));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    width_d    = width_q;
    height_d   = height_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    rom_addr_d = rom_addr_q;
    issue_d    = 1'b0;
    last_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (width != '0 && height != '0) begin
            state_d    = FETCH;
            width_d    = width;
            height_d   = height;
            stride_d   = row_stride;
            row_base_d = base_addr;
            col_d      = '0;
            row_d      = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (credit) begin
          rom_addr_d = row_base_q + ADDR_W'(col_q);
          issue_d    = 1'b1;
          last_d     = col_end && row_end;
          if (col_end) begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = row_base_q + stride_q;
            if (row_end) state_d = DRAIN;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!issue_q && fifo_count == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      rom_addr_q <= '0;
      issue_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      width_q    <= width_d;
      height_q   <= height_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      rom_addr_q <= rom_addr_d;
      issue_q    <= issue_d;
      last_q     <= last_d;
    end
  end

  // rom_data belongs to the address issued on the previous edge, tagged by issue_q/last_q.
  assign pop = !fifo_empty && out_if.out_ready;

  ifmap_fetch_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue_q),
    .wdata_i ({last_q, rom_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign rom_addr         = rom_addr_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_rdata[DATA_W-1:0];
  assign out_if.out_last  = fifo_rdata[DATA_W];

endmodule
